// File: rtl/rv_pkg.sv
// Shared constants and types for the RV32I writeback slice.
package rv_pkg;

  localparam int XLEN = 32;

  // Writeback source select codes
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_CSR  = 2'd3;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/rv_load_align.sv
// Extracts and extends the loaded byte/half/word from the raw memory word.
module rv_load_align
  import rv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lsb,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half-word, then extend per load type
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    byte_sel = data[7:0];
    half_sel = addr_lsb[1] ? data[31:16] : data[15:0];
    result   = data;
    case (addr_lsb)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/rv_writeback.sv
// Writeback stage: retires instructions, waits for load data, drives the
// register file write port and keeps the retired-instruction counter.
module rv_writeback
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_flush,
  input  logic [4:0]       i_rd,
  input  logic             i_wb_en,
  input  logic [1:0]       i_wb_sel,
  input  logic [2:0]       i_funct3,
  input  logic [1:0]       i_addr_lsb,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_csr_data,
  input  logic [XLEN-1:0]  i_load_data,
  input  logic             i_data_ack,
  output logic             o_wr,
  output logic [4:0]       o_rd,
  output logic [XLEN-1:0]  o_write_data,
  output logic             o_pend_valid,
  output logic [4:0]       o_pend_rd,
  output logic [CNT_W-1:0] o_instret
);

  wb_state_e       state_q, state_d;
  logic            accept;
  logic            latch_load;
  logic            retire;
  logic [4:0]      ret_rd;
  logic            ret_wb_en;
  logic [XLEN-1:0] ret_data;

  logic [4:0]      ld_rd_q;
  logic            ld_wb_en_q;
  logic [2:0]      ld_funct3_q;
  logic [1:0]      ld_lsb_q;
  logic [XLEN-1:0] load_result;

  assign o_ready      = rst_n && (state_q == IDLE);
  assign accept       = i_valid && o_ready && !i_flush;
  assign o_pend_valid = (state_q == WAIT_LOAD);
  assign o_pend_rd    = (o_pend_valid && ld_wb_en_q) ? ld_rd_q : 5'd0;

  rv_load_align u_load_align (
    .funct3   (ld_funct3_q),
    .addr_lsb (ld_lsb_q),
    .data     (i_load_data),
    .result   (load_result)
  );

  // State register; reset is synchronous so a reset-cycle ack is dropped
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, and which instruction (if any) retires this cycle
  always_comb begin
    state_d    = state_q;
    latch_load = 1'b0;
    retire     = 1'b0;
    ret_rd     = i_rd;
    ret_wb_en  = i_wb_en;
    ret_data   = i_alu_result;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (i_wb_sel == WB_LOAD) begin
            latch_load = 1'b1;
            state_d    = WAIT_LOAD;
          end else begin
            retire = 1'b1;
            case (i_wb_sel)
              WB_PC4:  ret_data = i_pc + XLEN'(4);
              WB_CSR:  ret_data = i_csr_data;
              default: ret_data = i_alu_result;
            endcase
          end
        end
      end
      WAIT_LOAD: begin
        ret_rd    = ld_rd_q;
        ret_wb_en = ld_wb_en_q;
        ret_data  = load_result;
        // Flush wins over a same-cycle ack: the load is squashed
        if (i_flush) begin
          state_d = IDLE;
        end else if (i_data_ack) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load bookkeeping, register-file write port and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_rd_q      <= 5'd0;
      ld_wb_en_q   <= 1'b0;
      ld_funct3_q  <= 3'd0;
      ld_lsb_q     <= 2'd0;
      o_wr         <= 1'b0;
      o_rd         <= 5'd0;
      o_write_data <= '0;
      o_instret    <= '0;
    end else begin
      o_wr <= 1'b0;
      if (latch_load) begin
        ld_rd_q     <= i_rd;
        ld_wb_en_q  <= i_wb_en;
        ld_funct3_q <= i_funct3;
        ld_lsb_q    <= i_addr_lsb;
      end
      if (retire) begin
        // x0 writes are suppressed but the instruction still counts
        o_wr         <= ret_wb_en && (ret_rd != 5'd0);
        o_rd         <= ret_rd;
        o_write_data <= ret_data;
        o_instret    <= o_instret + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv_writeback.sv
// Directed self-checking bench for rv_writeback.
module tb_rv_writeback;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_flush, i_wb_en, i_data_ack;
  logic [4:0]  i_rd;
  logic [1:0]  i_wb_sel, i_addr_lsb;
  logic [2:0]  i_funct3;
  logic [31:0] i_alu_result, i_pc, i_csr_data, i_load_data;
  logic        o_ready, o_wr, o_pend_valid;
  logic [4:0]  o_rd, o_pend_rd;
  logic [31:0] o_write_data;
  logic [63:0] o_instret;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_cnt;

  always #5 clk = ~clk;

  rv_writeback #(.XLEN(32), .CNT_W(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_flush      (i_flush),
    .i_rd         (i_rd),
    .i_wb_en      (i_wb_en),
    .i_wb_sel     (i_wb_sel),
    .i_funct3     (i_funct3),
    .i_addr_lsb   (i_addr_lsb),
    .i_alu_result (i_alu_result),
    .i_pc         (i_pc),
    .i_csr_data   (i_csr_data),
    .i_load_data  (i_load_data),
    .i_data_ack   (i_data_ack),
    .o_wr         (o_wr),
    .o_rd         (o_rd),
    .o_write_data (o_write_data),
    .o_pend_valid (o_pend_valid),
    .o_pend_rd    (o_pend_rd),
    .o_instret    (o_instret)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and samples sit 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_valid      = 1'b0;
    i_flush      = 1'b0;
    i_rd         = 5'd0;
    i_wb_en      = 1'b0;
    i_wb_sel     = WB_ALU;
    i_funct3     = 3'd0;
    i_addr_lsb   = 2'd0;
    i_alu_result = 32'h0;
    i_pc         = 32'h0;
    i_csr_data   = 32'h0;
    i_load_data  = 32'h0;
    i_data_ack   = 1'b0;
  endtask

  task automatic offer(input logic [1:0] sel, input logic [4:0] rd, input logic en,
                       input logic [2:0] f3, input logic [1:0] lsb, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] csr);
    i_valid      = 1'b1;
    i_wb_sel     = sel;
    i_rd         = rd;
    i_wb_en      = en;
    i_funct3     = f3;
    i_addr_lsb   = lsb;
    i_alu_result = alu;
    i_pc         = pc;
    i_csr_data   = csr;
  endtask

  // Accept a load, hold it for wait_cycles, then ack with word
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] lsb,
                         input logic [4:0] rd, input int wait_cycles, input logic [31:0] word,
                         input logic [31:0] exp_data);
    offer(WB_LOAD, rd, 1'b1, f3, lsb, 32'h0, 32'h0, 32'h0);
    step();
    i_valid = 1'b0;
    check({tag, "_pend_valid"}, 64'(o_pend_valid), 64'd1);
    check({tag, "_pend_rd"}, 64'(o_pend_rd), 64'(rd));
    for (int k = 0; k < wait_cycles; k++) begin
      step();
      check({tag, "_wait_ready"}, 64'(o_ready), 64'd0);
      check({tag, "_wait_wr"}, 64'(o_wr), 64'd0);
    end
    i_data_ack  = 1'b1;
    i_load_data = word;
    step();
    i_data_ack  = 1'b0;
    exp_cnt++;
    check({tag, "_wr"}, 64'(o_wr), 64'd1);
    check({tag, "_rd"}, 64'(o_rd), 64'(rd));
    check({tag, "_data"}, 64'(o_write_data), 64'(exp_data));
    check({tag, "_instret"}, o_instret, exp_cnt);
    check({tag, "_ready"}, 64'(o_ready), 64'd1);
    check({tag, "_pend_clr"}, 64'(o_pend_valid), 64'd0);
  endtask

  initial begin
    clear_inputs();
    rst_n   = 1'b0;
    exp_cnt = 64'd0;
    step();
    step();
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_wr", 64'(o_wr), 64'd0);
    check("rst_instret", o_instret, 64'd0);
    check("rst_pend", 64'(o_pend_valid), 64'd0);
    rst_n = 1'b1;
    step();
    check("idle_ready", 64'(o_ready), 64'd1);

    // ALU op, rd=5
    offer(WB_ALU, 5'd5, 1'b1, 3'd0, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    step();
    i_valid = 1'b0;
    exp_cnt++;
    check("alu_wr", 64'(o_wr), 64'd1);
    check("alu_rd", 64'(o_rd), 64'd5);
    check("alu_data", 64'(o_write_data), 64'hDEADBEEF);
    check("alu_instret", o_instret, exp_cnt);
    step();
    check("alu_wr_pulse", 64'(o_wr), 64'd0);

    // Ack while idle is ignored
    i_data_ack = 1'b1;
    step();
    i_data_ack = 1'b0;
    check("idle_ack_wr", 64'(o_wr), 64'd0);
    check("idle_ack_instret", o_instret, exp_cnt);

    // Loads: LB, then back-to-back LHU / LH / LW
    do_load("lb", F3_LB, 2'd3, 5'd7, 3, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lhu", F3_LHU, 2'd2, 5'd8, 0, 32'h8001_1234, 32'h0000_8001);
    do_load("lh", F3_LH, 2'd2, 5'd9, 1, 32'h8001_1234, 32'hFFFF_8001);
    do_load("lbu", F3_LBU, 2'd1, 5'd10, 0, 32'h0000_9A00, 32'h0000_009A);
    do_load("lw", F3_LW, 2'd1, 5'd11, 0, 32'h1357_9BDF, 32'h1357_9BDF);

    // Load with wb_en=0 reports pend_rd of 0
    offer(WB_LOAD, 5'd12, 1'b0, F3_LW, 2'd0, 32'h0, 32'h0, 32'h0);
    step();
    i_valid = 1'b0;
    check("noen_pend_rd", 64'(o_pend_rd), 64'd0);
    i_data_ack = 1'b1;
    step();
    i_data_ack = 1'b0;
    exp_cnt++;
    check("noen_wr", 64'(o_wr), 64'd0);
    check("noen_instret", o_instret, exp_cnt);

    // Flush together with ack in WAIT_LOAD
    offer(WB_LOAD, 5'd13, 1'b1, F3_LW, 2'd0, 32'h0, 32'h0, 32'h0);
    step();
    i_valid     = 1'b0;
    i_data_ack  = 1'b1;
    i_flush     = 1'b1;
    i_load_data = 32'h5555_AAAA;
    step();
    i_data_ack = 1'b0;
    i_flush    = 1'b0;
    check("flush_wr", 64'(o_wr), 64'd0);
    check("flush_instret", o_instret, exp_cnt);
    check("flush_ready", 64'(o_ready), 64'd1);

    // Valid with flush in IDLE is dropped
    offer(WB_ALU, 5'd14, 1'b1, 3'd0, 2'd0, 32'h1111_2222, 32'h0, 32'h0);
    i_flush = 1'b1;
    step();
    clear_inputs();
    check("iflush_wr", 64'(o_wr), 64'd0);
    check("iflush_instret", o_instret, exp_cnt);

    // x0 ALU op then back-to-back JAL with PC wrap
    offer(WB_ALU, 5'd0, 1'b1, 3'd0, 2'd0, 32'h0000_1234, 32'h0, 32'h0);
    step();
    exp_cnt++;
    check("x0_wr", 64'(o_wr), 64'd0);
    check("x0_instret", o_instret, exp_cnt);
    offer(WB_PC4, 5'd1, 1'b1, 3'd0, 2'd0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    step();
    exp_cnt++;
    check("jal_wr", 64'(o_wr), 64'd1);
    check("jal_rd", 64'(o_rd), 64'd1);
    check("jal_data", 64'(o_write_data), 64'd0);
    check("jal_instret", o_instret, exp_cnt);

    // CSR read, back-to-back
    offer(WB_CSR, 5'd3, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0, 32'hCAFE_F00D);
    step();
    exp_cnt++;
    check("csr_data", 64'(o_write_data), 64'hCAFE_F00D);
    check("csr_wr", 64'(o_wr), 64'd1);

    // wb_en=0 ALU op retires without writing
    offer(WB_ALU, 5'd4, 1'b0, 3'd0, 2'd0, 32'h7777_7777, 32'h0, 32'h0);
    step();
    i_valid = 1'b0;
    exp_cnt++;
    check("nowb_wr", 64'(o_wr), 64'd0);
    check("nowb_instret", o_instret, exp_cnt);

    // Counter wrap
    force dut.o_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.o_instret;
    check("wrap_preload", o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    offer(WB_ALU, 5'd6, 1'b1, 3'd0, 2'd0, 32'h0000_0042, 32'h0, 32'h0);
    step();
    i_valid = 1'b0;
    check("wrap_instret", o_instret, 64'd0);
    check("wrap_data", 64'(o_write_data), 64'h42);

    // Reset during WAIT_LOAD, ack in the reset cycle ignored
    offer(WB_LOAD, 5'd15, 1'b1, F3_LW, 2'd0, 32'h0, 32'h0, 32'h0);
    step();
    i_valid = 1'b0;
    check("rstld_pend", 64'(o_pend_valid), 64'd1);
    rst_n       = 1'b0;
    i_data_ack  = 1'b1;
    i_load_data = 32'hABCD_EF01;
    step();
    check("rstld_wr", 64'(o_wr), 64'd0);
    check("rstld_rd", 64'(o_rd), 64'd0);
    check("rstld_data", 64'(o_write_data), 64'd0);
    check("rstld_pend_valid", 64'(o_pend_valid), 64'd0);
    check("rstld_pend_rd", 64'(o_pend_rd), 64'd0);
    check("rstld_instret", o_instret, 64'd0);
    check("rstld_ready", 64'(o_ready), 64'd0);
    rst_n = 1'b1;
    step();
    i_data_ack = 1'b0;
    check("post_rst_wr", 64'(o_wr), 64'd0);
    check("post_rst_instret", o_instret, 64'd0);
    check("post_rst_ready", 64'(o_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
